mips_io_uart_tx: RTL and testbench
==================================

# mips_io_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the MIPS processor's MEM stage, on the same bus as the data memory. Store words addressed to its data register are queued in a small word FIFO and serialized LSB-byte-first as 8N1 frames on `TxD`. A status register lets software poll for FIFO space, transmitter idle and overflow.

## Interface
- `BASE_ADDR`, `32'h1001_0040`: byte address of the TX data register; the status register is at `BASE_ADDR+4`.
- `BAUD_DIV`, 434: clock cycles per serial bit, ≥2 (434 = 50 MHz / 115200).
- `FIFO_DEPTH`, 4: words of buffering, power of two, ≥2.
- `DATA_WIDTH`, 32: bus width, fixed at 32.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: bus write strobe from EX_MEM.
- `MemRead` in 1: bus read strobe from EX_MEM.
- `Address` in 32: bus byte address (ALU result).
- `WriteData` in 32: store data.
- `ReadData` out 32: status read data; 0 when not selected.
- `TxD` out 1: serial output, idle high.
- `Full` out 1: FIFO full.
- `Idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- **Decode:** `sel_data = MemWrite && Address==BASE_ADDR`. `sel_stat = MemRead && Address==BASE_ADDR+4`. Other addresses are ignored.
- **Push:**
  - `sel_data` with FIFO not full pushes `WriteData`.
  - `sel_data` when full and no pop in the same cycle drops the word and sets sticky `ovf`.
  - If full and a pop happens in the same cycle, the push is accepted.
- **Status read:** `ReadData` is combinational, `{28'b0, ovf, Idle, Full, ~empty}` (bits 3:0) when `sel_stat`, else 0. A `sel_stat` cycle clears `ovf` at the following edge. A set and a clear in the same cycle: the set wins.
- **FSM states:** IDLE, START, DATA, STOP. It holds a 32-bit shift word, `byte_idx` 0..3, `bit_idx` 0..7 and `baud_cnt`.
  - **IDLE:** `TxD=1`. If FIFO not empty: pop, load the word, `byte_idx=0`, go to START.
  - **START:** `TxD=0` for `BAUD_DIV` cycles, then DATA with `bit_idx=0`.
  - **DATA:** `TxD` = bit `bit_idx` of byte `byte_idx`, LSB first, each held `BAUD_DIV` cycles. After bit 7 go to STOP.
  - **STOP:** `TxD=1` for `BAUD_DIV` cycles, then:
    - if `byte_idx<3`: increment it, go to START;
    - else if FIFO not empty: pop, load, `byte_idx=0`, go to START (no idle gap);
    - else go to IDLE.
- **Byte order:** little-endian; byte 0 = `WriteData[7:0]`.
- **Baud counter:** `baud_cnt` loads `BAUD_DIV-1` on every state or bit change and counts down. The transition happens when it reaches 0.

## Timing
- **Reset values:** `TxD=1`, `Full=0`, `Idle=1`, `ReadData=0`, `ovf=0`, FIFO empty, FSM IDLE, all counters 0.
- **Reset mid-frame:** the frame aborts immediately, `TxD` returns high asynchronously, and queued words are discarded.
- **Start latency:** a word accepted at edge k into an empty FIFO with the FSM in IDLE drives `TxD` low from edge k+1.
- **Word time:** exactly `40*BAUD_DIV` cycles per word. Back-to-back words have zero gap.
- **Flags:** `Full` and `Idle` are registered-state derived and update on the edge of the push or pop.
- **Throughput:** one push is accepted per cycle.

## Structure
- **Package `mips_io_pkg`:** FSM state enum; register offsets (`TX_DATA_OFS=0`, `TX_STAT_OFS=4`); status bit indices (`ST_NOTEMPTY=0`, `ST_FULL=1`, `ST_IDLE=2`, `ST_OVF=3`).
- **Sub-module `io_word_fifo`:**
  - parameterized `WIDTH` and `DEPTH`;
  - ports `push`/`pop`/`din`/`dout`/`full`/`empty`;
  - wrap-around pointers with an extra MSB;
  - simultaneous push and pop allowed when full or empty-with-push.
- **Top level:** contains only decode, status and the FSM.

## Test plan
All scenarios use `BAUD_DIV=4` and `FIFO_DEPTH=4`.
1. **Reset:** assert `reset` low → `TxD=1`, `Idle=1`, `Full=0`; status read returns `32'h4`.
2. **Single word:** write `32'h4B00A531` to `BASE_ADDR` → `TxD` low 1 cycle later; bytes `0x31`, `0xA5`, `0x00`, `0x4B` appear LSB-first, each bit 4 cycles; `Idle=1` exactly 160 cycles after the start bit.
3. **Full and overflow:** five writes in consecutive cycles (first pops immediately) → all 5 accepted and `Full=1`; a sixth write is dropped; status reads `32'hB`, and the next read shows `ovf=0`.
4. **Push at pop edge:** with the FIFO full, write in the same cycle as the STOP→START pop → word accepted, `ovf` stays 0, `Full` stays 1.
5. **Decode:** write to `BASE_ADDR+8` and read `BASE_ADDR` → no push, `ReadData=0`, `TxD` stays 1.
6. **Reset mid-frame:** pull `reset` low during DATA bit 3 of byte 2 → `TxD=1` immediately; after release `Idle=1` and the remaining words are gone.

Source files
------------

// File: rtl/mips_io_pkg.sv
// mips_io_pkg: shared types for the memory-mapped UART transmitter.
// FSM state encoding, register offsets and status bit positions.
package mips_io_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam logic [31:0] TX_DATA_OFS = 32'd0;
  localparam logic [31:0] TX_STAT_OFS = 32'd4;

  localparam int ST_NOTEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_IDLE     = 2;
  localparam int ST_OVF      = 3;

endpackage

// File: rtl/mips_io_uart_tx_if.sv
// mips_io_uart_tx_if: MEM-stage data bus as seen by the UART.
// master = CPU side (strobes, address, store data); slave = device.
interface mips_io_uart_tx_if;

  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output ReadData
  );

endinterface

// File: rtl/io_word_fifo.sv
// io_word_fifo: word FIFO, pointers with an extra wrap bit.
// Ports: push/din in, pop/dout out, full/empty flags.
module io_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push into
  // a full FIFO is still taken when a pop accompanies it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/mips_io_uart_tx.sv
// mips_io_uart_tx: store-fed 8N1 UART TX with word FIFO and status reg.
// Ports: clk, reset (async low), bus (slave), TxD, Full, Idle.
module mips_io_uart_tx
  import mips_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 4,
  parameter int          DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mips_io_uart_tx_if.slave  bus,
  output logic              TxD,
  output logic              Full,
  output logic              Idle
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                  sel_data;
  logic                  sel_stat;
  logic                  pop;
  logic                  empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [31:0]           rdata;
  logic                  ovf;
  logic                  bit_end;

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [1:0]            byte_idx;
  logic [2:0]            bit_idx;
  logic [CW-1:0]         baud_cnt;
  logic                  txd_q;

  assign sel_data = bus.MemWrite &&
                    (bus.Address == BASE_ADDR + TX_DATA_OFS);
  assign sel_stat = bus.MemRead &&
                    (bus.Address == BASE_ADDR + TX_STAT_OFS);

  assign bit_end = (baud_cnt == '0);

  // Pop when idle, or at the end of the last stop bit of a word
  // so the next word follows with no idle gap.
  assign pop = !empty &&
               ((state == S_IDLE) ||
                (state == S_STOP && bit_end && byte_idx == 2'd3));

  io_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (sel_data),
    .pop   (pop),
    .din   (bus.WriteData),
    .dout  (fifo_dout),
    .full  (Full),
    .empty (empty)
  );

  assign Idle = empty && (state == S_IDLE);
  assign TxD  = txd_q;

  always_comb begin
    rdata = '0;
    if (sel_stat) begin
      rdata[ST_NOTEMPTY] = !empty;
      rdata[ST_FULL]     = Full;
      rdata[ST_IDLE]     = Idle;
      rdata[ST_OVF]      = ovf;
    end
  end

  assign bus.ReadData = rdata;

  // A dropped word in the same cycle as a status read keeps ovf set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (sel_data && Full && !pop) begin
      ovf <= 1'b1;
    end else if (sel_stat) begin
      ovf <= 1'b0;
    end
  end

  // The word is shifted out from bit 0 upward; with little-endian
  // byte order that is exactly byte 0..3, each LSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      shift    <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      txd_q    <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift    <= fifo_dout;
            byte_idx <= '0;
            baud_cnt <= CNT_LAST;
            txd_q    <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_idx  <= '0;
            txd_q    <= shift[0];
            shift    <= shift >> 1;
            baud_cnt <= CNT_LAST;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= CNT_LAST;
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= CNT_LAST;
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              txd_q    <= 1'b0;
              state    <= S_START;
            end else if (pop) begin
              shift    <= fifo_dout;
              byte_idx <= '0;
              txd_q    <= 1'b0;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_io_uart_tx.sv
// tb_mips_io_uart_tx: directed bench for the UART TX block.
// Vector table for bus decode plus hand-timed frame sequences.
module tb_mips_io_uart_tx;

  localparam logic [31:0] BASE = 32'h1001_0040;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic TxD;
  logic Full;
  logic Idle;

  int tests = 0;
  int fails = 0;

  mips_io_uart_tx_if bus();

  mips_io_uart_tx #(
    .BASE_ADDR  (BASE),
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .TxD   (TxD),
    .Full  (Full),
    .Idle  (Idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } bus_vec_t;

  bus_vec_t vecs [6];
  logic [7:0] exp_bytes [4];
  logic [31:0] exp_words [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
  endtask

  task automatic bw(input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    bus.Address   = BASE;
    bus.WriteData = d;
  endtask

  task automatic stat_rd();
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.Address  = BASE + 32'd4;
  endtask

  // Call just after the frame-start edge; samples 160 cycles.
  task automatic rx_word(output logic [31:0] w, output int ferr);
    logic [9:0] fr;
    w = '0;
    ferr = 0;
    fr = '0;
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < BD; c++) begin
          @(negedge clk);
          if (c == 0) fr[b] = TxD;
          else if (TxD !== fr[b]) ferr++;
          if (Idle !== 1'b0) ferr++;
        end
      end
      if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ferr++;
      w[8*j +: 8] = fr[8:1];
    end
  endtask

  initial begin
    logic [31:0] w;
    int ferr;
    int errs;

    vecs[0] = '{1'b1, 1'b0, BASE + 32'd8,  32'h5555_AAAA, 32'h0};
    vecs[1] = '{1'b0, 1'b1, BASE,          32'h0,         32'h0};
    vecs[2] = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h4};
    vecs[3] = '{1'b1, 1'b0, BASE + 32'd4,  32'h1234_5678, 32'h0};
    vecs[4] = '{1'b0, 1'b1, BASE + 32'd12, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 1'b0, BASE + 32'd4,  32'h0,         32'h0};
    exp_bytes[0] = 8'h31;
    exp_bytes[1] = 8'hA5;
    exp_bytes[2] = 8'h00;
    exp_bytes[3] = 8'h4B;
    exp_words[0] = 32'hA1B2_C3D4;
    exp_words[1] = 32'h0F0F_F0F0;
    exp_words[2] = 32'h8000_0001;
    exp_words[3] = 32'h7E7E_5AA5;
    exp_words[4] = 32'h1357_9BDF;

    idle_bus();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    stat_rd();
    #1;
    chk("rst_txd", TxD, 1'b1);
    chk("rst_idle", Idle, 1'b1);
    chk("rst_full", Full, 1'b0);
    chk("rst_stat", bus.ReadData, 32'h4);
    reset = 1'b1;
    idle_bus();
    tick();

    // single word
    bw(32'h4B00_A531);
    tick();
    idle_bus();
    #1;
    chk("one_txd_pre", TxD, 1'b1);
    chk("one_idle_pre", Idle, 1'b0);
    @(posedge clk);
    rx_word(w, ferr);
    chk("one_frame", ferr, 0);
    for (int j = 0; j < 4; j++)
      chk($sformatf("one_byte%0d", j), w[8*j +: 8], exp_bytes[j]);
    chk("one_idle_160", Idle, 1'b0);
    @(negedge clk);
    chk("one_idle_161", Idle, 1'b1);
    chk("one_txd_end", TxD, 1'b1);

    // decode table
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.MemWrite  = vecs[i].we;
      bus.MemRead   = vecs[i].re;
      bus.Address   = vecs[i].addr;
      bus.WriteData = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rd", i), bus.ReadData, vecs[i].exp_rd);
      tick();
      idle_bus();
      chk($sformatf("vec%0d_idle", i), Idle, 1'b1);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1) errs++;
    end
    chk("dec_txd_high", errs, 0);

    // full and overflow
    tick();
    bw(32'h0000_0001);
    tick();
    bw(exp_words[0]);
    tick();
    bw(exp_words[1]);
    tick();
    bw(exp_words[2]);
    tick();
    bw(exp_words[3]);
    tick();
    chk("ovf_full5", Full, 1'b1);
    bw(32'hDEAD_BEEF);
    tick();
    stat_rd();
    #1;
    chk("ovf_stat_b", bus.ReadData, 32'hB);
    chk("ovf_full6", Full, 1'b1);
    tick();
    chk("ovf_stat_clr", bus.ReadData, 32'h3);
    idle_bus();

    // push on the STOP->START pop edge
    repeat (154) tick();
    chk("pe_full_pre", Full, 1'b1);
    bw(exp_words[4]);
    tick();
    stat_rd();
    #1;
    chk("pe_stat", bus.ReadData, 32'h3);
    chk("pe_full", Full, 1'b1);
    idle_bus();
    for (int i = 0; i < 5; i++) begin
      rx_word(w, ferr);
      chk($sformatf("pe_frame%0d", i), ferr, 0);
      chk($sformatf("pe_word%0d", i), w, exp_words[i]);
    end
    @(negedge clk);
    chk("pe_idle_end", Idle, 1'b1);
    chk("pe_full_end", Full, 1'b0);

    // reset mid-frame, byte 2 bit 3
    tick();
    bw(32'hC3F7_5AA5);
    tick();
    bw(32'h1111_1111);
    tick();
    bw(32'h2222_2222);
    tick();
    idle_bus();
    repeat (96) tick();
    #2;
    chk("mr_in_frame", TxD, 1'b0);
    reset = 1'b0;
    #1;
    chk("mr_txd_async", TxD, 1'b1);
    chk("mr_idle_async", Idle, 1'b1);
    chk("mr_full_async", Full, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Idle !== 1'b1) errs++;
    end
    chk("mr_quiet", errs, 0);
    tick();
    stat_rd();
    #1;
    chk("mr_stat", bus.ReadData, 32'h4);
    idle_bus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
